regfile_wb_sched: RTL



---
 rtl/regfile_wb_sched_pkg.sv | 34 +++
 rtl/regfile_wb_sched_if.sv | 55 +++++
 rtl/regfile_wb_sched_rr_arb.sv | 44 ++++
 rtl/regfile_wb_sched.sv | 131 +++++++++++++
 4 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants, source-select and round-robin pointer types, and the
// register hazard check for the writeback scheduler.
package regfile_wb_pkg;

  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int NREG = 2 ** AW;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_DIV,
    WB_LD
  } wb_src_t;

  typedef enum logic {
    RR_DIV,
    RR_LD
  } rr_ptr_t;

  // A register is hazardous while its long op is outstanding or while its
  // write still sits in a port register, so issue only ever reads committed data.
  function automatic logic hz(
    input logic [NREG-1:0] sb,
    input logic [AW-1:0]   a,
    input logic            dwen_n,
    input logic [AW-1:0]   dwa,
    input logic            swen_n,
    input logic [AW-1:0]   swa
  );
    return sb[a] | (~dwen_n & (dwa == a)) | (~swen_n & (swa == a));
  endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Bus bundle between issue/divide/memory requesters and the writeback
// scheduler; master drives requests, slave is the scheduler.
interface regfile_wb_sched_if;
  import regfile_wb_pkg::*;

  logic          alu_wen;
  logic [AW-1:0] alu_wa;
  logic [DW-1:0] alu_wd;

  logic          div_req;
  logic [AW-1:0] div_wa;
  logic [DW-1:0] div_wd;
  logic          div_ack;

  logic          ld_req;
  logic [AW-1:0] ld_wa;
  logic [DW-1:0] ld_wd;
  logic          ld_ack;

  logic          iss_valid;
  logic [AW-1:0] iss_srca;
  logic [AW-1:0] iss_dsta;
  logic          iss_lng;
  logic          stall;

  logic [AW-1:0] dstwa;
  logic [DW-1:0] dstwd;
  logic          dstrwen_n;
  logic [AW-1:0] srcwa;
  logic [DW-1:0] srcwd;
  logic          srcrwen_n;

  logic [15:0]   stall_cnt;

  modport master (
    output alu_wen, alu_wa, alu_wd,
    output div_req, div_wa, div_wd,
    output ld_req, ld_wa, ld_wd,
    output iss_valid, iss_srca, iss_dsta, iss_lng,
    input  div_ack, ld_ack, stall,
    input  dstwa, dstwd, dstrwen_n, srcwa, srcwd, srcrwen_n,
    input  stall_cnt
  );

  modport slave (
    input  alu_wen, alu_wa, alu_wd,
    input  div_req, div_wa, div_wd,
    input  ld_req, ld_wa, ld_wd,
    input  iss_valid, iss_srca, iss_dsta, iss_lng,
    output div_ack, ld_ack, stall,
    output dstwa, dstwd, dstrwen_n, srcwa, srcwd, srcrwen_n,
    output stall_cnt
  );

endinterface

// File: rtl/regfile_wb_sched_rr_arb.sv
// Two-way round-robin arbiter between divider and load results for the
// src write port; hold_i freezes the pointer when both requesters are served.
//
// state  | meaning
// RR_DIV | divider wins a tie next
// RR_LD  | load wins a tie next
module wb_rr_arb
  import regfile_wb_pkg::*;
(
  input  logic clk,
  input  logic resetl,
  input  logic req_div_i,
  input  logic req_ld_i,
  input  logic hold_i,
  output logic gnt_div_o,
  output logic gnt_ld_o
);

  rr_ptr_t ptr_q, ptr_d;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) ptr_q <= RR_DIV;
    else         ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_div_o = 1'b0;
    gnt_ld_o  = 1'b0;
    ptr_d     = ptr_q;
    if (req_div_i && req_ld_i) begin
      if (ptr_q == RR_DIV) gnt_div_o = 1'b1;
      else                 gnt_ld_o  = 1'b1;
    end else begin
      gnt_div_o = req_div_i;
      gnt_ld_o  = req_ld_i;
    end
    // Pointer moves to whoever did not win; both-served cycles leave it alone.
    if (!hold_i) begin
      if (gnt_div_o)     ptr_d = RR_LD;
      else if (gnt_ld_o) ptr_d = RR_DIV;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and hazard scoreboard for the dual-write-port register
// file. Optional stall statistics counter built when WB_STALLCNT_EN is defined.
module regfile_wb_sched
  import regfile_wb_pkg::*;
(
  input  logic               clk,
  input  logic               resetl,
  regfile_wb_sched_if.slave  bus
);

  logic          gnt_div, gnt_ld;
  logic          both_sec, dup_wa, dst_we, issue_lng, stall;
  wb_src_t       dst_sel, src_sel;
  logic [AW-1:0] dst_wa_d, src_wa_d;
  logic [DW-1:0] dst_wd_d, src_wd_d;

  logic          dst_wen_n_q, src_wen_n_q;
  logic [AW-1:0] dst_wa_q, src_wa_q;
  logic [DW-1:0] dst_wd_q, src_wd_q;
  logic [NREG-1:0] sb_q, sb_d;

  assign both_sec = ~bus.alu_wen & bus.div_req & bus.ld_req;
  assign dup_wa   = both_sec & (bus.div_wa == bus.ld_wa);

  wb_rr_arb u_arb (
    .clk       (clk),
    .resetl    (resetl),
    .req_div_i (bus.div_req),
    .req_ld_i  (bus.ld_req),
    .hold_i    (both_sec),
    .gnt_div_o (gnt_div),
    .gnt_ld_o  (gnt_ld)
  );

  // ALU owns dst when present; otherwise the arbitration loser borrows it.
  always_comb begin
    dst_sel = WB_NONE;
    src_sel = WB_NONE;
    if (gnt_div)     src_sel = WB_DIV;
    else if (gnt_ld) src_sel = WB_LD;
    if (bus.alu_wen)   dst_sel = WB_ALU;
    else if (both_sec) dst_sel = gnt_div ? WB_LD : WB_DIV;
  end

  assign bus.div_ack = (src_sel == WB_DIV) | (dst_sel == WB_DIV);
  assign bus.ld_ack  = (src_sel == WB_LD)  | (dst_sel == WB_LD);
  // Same-address double ack: only the src-port write survives.
  assign dst_we      = (dst_sel != WB_NONE) & ~dup_wa;

  always_comb begin
    dst_wa_d = '0;
    dst_wd_d = '0;
    src_wa_d = '0;
    src_wd_d = '0;
    case (dst_sel)
      WB_ALU:  begin dst_wa_d = bus.alu_wa; dst_wd_d = bus.alu_wd; end
      WB_DIV:  begin dst_wa_d = bus.div_wa; dst_wd_d = bus.div_wd; end
      WB_LD:   begin dst_wa_d = bus.ld_wa;  dst_wd_d = bus.ld_wd;  end
      default: ;
    endcase
    case (src_sel)
      WB_DIV:  begin src_wa_d = bus.div_wa; src_wd_d = bus.div_wd; end
      WB_LD:   begin src_wa_d = bus.ld_wa;  src_wd_d = bus.ld_wd;  end
      default: ;
    endcase
  end

  assign stall = bus.iss_valid &
                 (hz(sb_q, bus.iss_srca, dst_wen_n_q, dst_wa_q, src_wen_n_q, src_wa_q) |
                  hz(sb_q, bus.iss_dsta, dst_wen_n_q, dst_wa_q, src_wen_n_q, src_wa_q));
  assign issue_lng = bus.iss_valid & ~stall & bus.iss_lng;

  // Set after clear so a new long op to a just-retired register stays pending.
  always_comb begin
    sb_d = sb_q;
    if (bus.div_ack) sb_d[bus.div_wa] = 1'b0;
    if (bus.ld_ack)  sb_d[bus.ld_wa]  = 1'b0;
    if (issue_lng)   sb_d[bus.iss_dsta] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      dst_wen_n_q <= 1'b1;
      src_wen_n_q <= 1'b1;
      dst_wa_q    <= '0;
      dst_wd_q    <= '0;
      src_wa_q    <= '0;
      src_wd_q    <= '0;
      sb_q        <= '0;
    end else begin
      dst_wen_n_q <= ~dst_we;
      src_wen_n_q <= (src_sel == WB_NONE);
      if (dst_we) begin
        dst_wa_q <= dst_wa_d;
        dst_wd_q <= dst_wd_d;
      end
      if (src_sel != WB_NONE) begin
        src_wa_q <= src_wa_d;
        src_wd_q <= src_wd_d;
      end
      sb_q <= sb_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.dstrwen_n = dst_wen_n_q;
  assign bus.dstwa     = dst_wa_q;
  assign bus.dstwd     = dst_wd_q;
  assign bus.srcrwen_n = src_wen_n_q;
  assign bus.srcwa     = src_wa_q;
  assign bus.srcwd     = src_wd_q;

`ifdef WB_STALLCNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) stall_cnt_q <= 16'h0000;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule
